// File: rtl/uart_rx.sv
// uart_rx: oversampled 8-bit UART receiver with optional parity, framing/parity error pulses and sticky overrun.
module uart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pulse_uart,
  input  logic       enable,
  input  logic       rx,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       framing_err,
  output logic       parity_err,
  output logic       overrun,
  output logic       busy
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_FULL = TW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d, data_q, data_d;
  logic          s1_q, s2_q, last_q, last_d;
  logic          mism_q, mism_d;
  logic          valid_q, valid_d, ferr_q, ferr_d, perr_q, perr_d, ovr_q, ovr_d;
  logic          rxs;

  assign rxs         = s2_q;
  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign framing_err = ferr_q;
  assign parity_err  = perr_q;
  assign overrun     = ovr_q;
  assign busy        = state_q != IDLE;

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      last_q  <= 1'b1;
      mism_q  <= 1'b0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      s1_q    <= rx;
      s2_q    <= s1_q;
      last_q  <= last_d;
      mism_q  <= mism_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
      ovr_q   <= ovr_d;
    end

  // last_q holds rxs as of the previous tick, so a line held low never looks like a new start edge
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    data_d  = data_q;
    mism_d  = mism_q;
    last_d  = pulse_uart ? rxs : last_q;
    valid_d = rx_ack ? 1'b0 : valid_q;
    ovr_d   = rx_ack ? 1'b0 : ovr_q;
    ferr_d  = 1'b0;
    perr_d  = 1'b0;
    if (!enable && state_q != IDLE) begin
      state_d = IDLE;
      tick_d  = '0;
      bit_d   = '0;
    end else if (pulse_uart) begin
      case (state_q)
        IDLE:
          if (enable && last_q && !rxs) begin
            state_d = START;
            tick_d  = '0;
            mism_d  = 1'b0;
          end
        START:
          if (tick_q == T_HALF) begin
            tick_d  = '0;
            bit_d   = '0;
            state_d = rxs ? IDLE : DATA;
          end else tick_d = tick_q + TW'(1);
        DATA:
          if (tick_q == T_FULL) begin
            tick_d  = '0;
            sh_d    = {rxs, sh_q[7:1]};
            bit_d   = bit_q + 3'd1;
            state_d = bit_q != 3'd7 ? DATA : PARITY_EN != 0 ? PARITY : STOP;
          end else tick_d = tick_q + TW'(1);
        PARITY:
          if (tick_q == T_FULL) begin
            tick_d  = '0;
            mism_d  = (^sh_q ^ rxs) != 1'(PARITY_ODD);
            state_d = STOP;
          end else tick_d = tick_q + TW'(1);
        STOP:
          if (tick_q == T_FULL) begin
            tick_d  = '0;
            state_d = IDLE;
            ferr_d  = !rxs;
            perr_d  = rxs && mism_q;
            if (rxs && !mism_q) begin
              data_d  = sh_q;
              valid_d = 1'b1;
              ovr_d   = (valid_q || ovr_q) && !rx_ack;
            end
          end else tick_d = tick_q + TW'(1);
        default: state_d = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed scenario tests for uart_rx (8N1 instance plus an even-parity instance).
module tb_uart_rx;
  logic       clk = 1'b0, rst = 1'b0, pulse_uart = 1'b0, enable = 1'b1, rx = 1'b1, rx_p = 1'b1, rx_ack = 1'b0;
  logic [7:0] rx_data, rx_data_p;
  logic       rx_valid, framing_err, parity_err, overrun, busy;
  logic       rx_valid_p, framing_err_p, parity_err_p, overrun_p, busy_p;
  logic       sel = 1'b0;
  int         n_cmp = 0, n_fail = 0;
  int         cyc = 0, v_rise = -1, b_fall = -2, f_hi = 0, f_rise = 0, p_hi = 0, p_rise = 0;
  logic       vprev = 1'b0, bprev = 1'b0, fprev = 1'b0, pprev = 1'b0;

  uart_rx u_dut (
    .clk(clk), .rst(rst), .pulse_uart(pulse_uart), .enable(enable), .rx(rx), .rx_ack(rx_ack),
    .rx_data(rx_data), .rx_valid(rx_valid), .framing_err(framing_err), .parity_err(parity_err),
    .overrun(overrun), .busy(busy)
  );

  uart_rx #(.OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0)) u_par (
    .clk(clk), .rst(rst), .pulse_uart(pulse_uart), .enable(enable), .rx(rx_p), .rx_ack(rx_ack),
    .rx_data(rx_data_p), .rx_valid(rx_valid_p), .framing_err(framing_err_p), .parity_err(parity_err_p),
    .overrun(overrun_p), .busy(busy_p)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    repeat (3) @(posedge clk);
    #1 pulse_uart = 1'b1;
    @(posedge clk);
    #1 pulse_uart = 1'b0;
  end

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    vprev  <= rx_valid;
    bprev  <= busy;
    fprev  <= framing_err;
    pprev  <= parity_err_p;
    if (rx_valid && !vprev) v_rise <= cyc;
    if (!busy && bprev) b_fall <= cyc;
    f_hi   <= f_hi + int'(framing_err);
    f_rise <= f_rise + int'(framing_err && !fprev);
    p_hi   <= p_hi + int'(parity_err_p);
    p_rise <= p_rise + int'(parity_err_p && !pprev);
  end

  task automatic wait_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      for (int g = 0; g < 16 && !pulse_uart; g++) @(posedge clk);
    end
    #2;
  endtask

  task automatic drive(input logic b);
    rx   = sel ? 1'b1 : b;
    rx_p = sel ? b : 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int par);
    drive(1'b0);
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      drive(d[i]);
      wait_ticks(16);
    end
    if (par >= 0) begin
      drive(par[0]);
      wait_ticks(16);
    end
    drive(stop);
    wait_ticks(16);
    drive(1'b1);
    wait_ticks(4);
  endtask

  task automatic ack();
    rx_ack = 1'b1;
    @(posedge clk);
    #2 rx_ack = 1'b0;
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    #23;
    n_cmp++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h exp 00", rx_data); end
    n_cmp++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", rx_valid); end
    n_cmp++; if (framing_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr got %b exp 0", framing_err); end
    n_cmp++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_perr got %b exp 0", parity_err); end
    n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_ovr got %b exp 0", overrun); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    rst = 1'b1;
    wait_ticks(20);
  endtask

  task automatic test_basic();
    int f0;
    f0 = f_rise;
    send_frame(8'hA5, 1'b1, -1);
    n_cmp++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %b exp 1", rx_valid); end
    n_cmp++; if (rx_data !== 8'hA5) begin n_fail++; $display("FAIL basic_data got %h exp a5", rx_data); end
    n_cmp++; if (v_rise !== b_fall) begin n_fail++; $display("FAIL basic_latency valid_cyc %0d exp %0d", v_rise, b_fall); end
    n_cmp++; if (f_rise !== f0) begin n_fail++; $display("FAIL basic_ferr got %0d exp %0d", f_rise, f0); end
    ack();
    n_cmp++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL basic_ack_valid got %b exp 0", rx_valid); end
  endtask

  task automatic test_glitch();
    int f0;
    f0 = f_rise;
    rx = 1'b0;
    wait_ticks(4);
    rx = 1'b1;
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_start got %b exp 1", busy); end
    wait_ticks(16);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_end got %b exp 0", busy); end
    n_cmp++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL glitch_valid got %b exp 0", rx_valid); end
    n_cmp++; if (f_rise !== f0 || parity_err !== 1'b0) begin n_fail++; $display("FAIL glitch_flags ferr %0d exp %0d", f_rise, f0); end
  endtask

  task automatic test_framing();
    int f0, h0;
    f0 = f_rise;
    h0 = f_hi;
    send_frame(8'h3C, 1'b0, -1);
    n_cmp++; if (f_rise - f0 !== 1) begin n_fail++; $display("FAIL framing_pulses got %0d exp 1", f_rise - f0); end
    n_cmp++; if (f_hi - h0 !== 1) begin n_fail++; $display("FAIL framing_width got %0d exp 1", f_hi - h0); end
    n_cmp++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL framing_valid got %b exp 0", rx_valid); end
    n_cmp++; if (rx_data !== 8'hA5) begin n_fail++; $display("FAIL framing_data got %h exp a5", rx_data); end
  endtask

  task automatic test_overrun();
    send_frame(8'h11, 1'b1, -1);
    n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_first got %b exp 0", overrun); end
    send_frame(8'h22, 1'b1, -1);
    n_cmp++; if (rx_data !== 8'h22) begin n_fail++; $display("FAIL ovr_data got %h exp 22", rx_data); end
    n_cmp++; if (overrun !== 1'b1 || rx_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_set ovr %b valid %b exp 1 1", overrun, rx_valid); end
    ack();
    n_cmp++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_ack_valid got %b exp 0", rx_valid); end
    n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_ack_ovr got %b exp 0", overrun); end
  endtask

  task automatic test_parity();
    int p0, h0;
    sel = 1'b1;
    p0 = p_rise;
    h0 = p_hi;
    send_frame(8'h07, 1'b1, 0);
    n_cmp++; if (p_rise - p0 !== 1 || p_hi - h0 !== 1) begin n_fail++; $display("FAIL parity_bad_pulse rises %0d cycles %0d exp 1 1", p_rise - p0, p_hi - h0); end
    n_cmp++; if (rx_valid_p !== 1'b0) begin n_fail++; $display("FAIL parity_bad_valid got %b exp 0", rx_valid_p); end
    send_frame(8'h07, 1'b1, 1);
    n_cmp++; if (rx_valid_p !== 1'b1) begin n_fail++; $display("FAIL parity_good_valid got %b exp 1", rx_valid_p); end
    n_cmp++; if (rx_data_p !== 8'h07) begin n_fail++; $display("FAIL parity_good_data got %h exp 07", rx_data_p); end
    n_cmp++; if (p_rise - p0 !== 1) begin n_fail++; $display("FAIL parity_good_noerr got %0d exp 1", p_rise - p0); end
    sel = 1'b0;
  endtask

  task automatic test_break();
    int f0;
    f0 = f_rise;
    rx = 1'b0;
    wait_ticks(200);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL break_retrigger busy %b exp 0", busy); end
    n_cmp++; if (f_rise - f0 !== 1) begin n_fail++; $display("FAIL break_ferr got %0d exp 1", f_rise - f0); end
    rx = 1'b1;
    wait_ticks(4);
  endtask

  task automatic test_enable_abort();
    int f0;
    f0 = f_rise;
    rx = 1'b0;
    wait_ticks(40);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy_before got %b exp 1", busy); end
    enable = 1'b0;
    @(posedge clk);
    #2;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b exp 0", busy); end
    rx = 1'b1;
    wait_ticks(8);
    enable = 1'b1;
    wait_ticks(8);
    n_cmp++; if (rx_valid !== 1'b0 || f_rise !== f0) begin n_fail++; $display("FAIL abort_flags valid %b ferr %0d exp 0 %0d", rx_valid, f_rise, f0); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    d = 8'h5A;
    send_frame(8'h33, 1'b1, -1);
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      wait_ticks(16);
    end
    wait_ticks(8);
    rst = 1'b0;
    #2;
    n_cmp++; if (rx_valid !== 1'b0 || rx_data !== 8'h00) begin n_fail++; $display("FAIL rstmid_out valid %b data %h exp 0 00", rx_valid, rx_data); end
    n_cmp++; if (busy !== 1'b0 || overrun !== 1'b0) begin n_fail++; $display("FAIL rstmid_state busy %b ovr %b exp 0 0", busy, overrun); end
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    wait_ticks(20);
    send_frame(8'h5A, 1'b1, -1);
    n_cmp++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_valid got %b exp 1", rx_valid); end
    n_cmp++; if (rx_data !== 8'h5A) begin n_fail++; $display("FAIL rstmid_data got %h exp 5a", rx_data); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_framing();
    test_overrun();
    test_parity();
    test_break();
    test_enable_abort();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16, giving pulse_uart ticks per bit; legal values are even numbers from 4 to 64.
REQ-002 SHALL have parameter PARITY_EN, default 0; 1 means a parity bit follows the data bits.
REQ-003 SHALL have parameter PARITY_ODD, default 0; 0 selects even parity, 1 selects odd parity; ignored when PARITY_EN=0.
REQ-004 SHALL have one clock and an asynchronous, active-low reset; the ports are named as below.
REQ-005 clk  input  1  system clock; all logic is on the rising edge.
REQ-006 rst  input  1  asynchronous reset, active-low.
REQ-007 pulse_uart  input  1  one-clk-wide oversample tick at OVERSAMPLE x baud.
REQ-008 enable  input  1  receiver enable.
REQ-009 rx  input  1  asynchronous serial line; idle level is 1.
REQ-010 rx_ack  input  1  consumer acknowledge; clears rx_valid and overrun.
REQ-011 rx_data  output  8  last good received byte, LSB received first.
REQ-012 rx_valid  output  1  rx_data holds an unacknowledged byte.
REQ-013 framing_err  output  1  one-clk pulse when the stop bit is sampled as 0.
REQ-014 parity_err  output  1  one-clk pulse on a parity mismatch.
REQ-015 overrun  output  1  sticky flag: a byte arrived while rx_valid=1 and was not acknowledged.
REQ-016 busy  output  1  1 whenever the FSM is not in IDLE.

Function
REQ-017 rx SHALL pass through a 2-flop synchronizer whose flops reset to 1; all decisions use the synchronized value rxs.
REQ-018 The FSM SHALL have the states IDLE, START, DATA, PARITY, STOP; the tick counter and bit counter SHALL advance only on cycles where pulse_uart=1.
REQ-019 IDLE: on a pulse_uart tick with enable=1 and a falling edge of rxs (previous 1, current 0), go to START and clear the tick counter.
REQ-020 START: after OVERSAMPLE/2 ticks, sample rxs; if 0, go to DATA; if 1, treat it as a glitch and return to IDLE with no flags.
REQ-021 DATA: sample rxs every OVERSAMPLE ticks (mid-bit); shift it into bit 7 of the shift register and right-shift; after 8 samples, go to PARITY if PARITY_EN=1, otherwise to STOP.
REQ-022 PARITY: sample one bit after OVERSAMPLE ticks; record a mismatch if the XOR of the data and parity bit is not equal to PARITY_ODD; go to STOP.
REQ-023 STOP: sample rxs after OVERSAMPLE ticks and always return to IDLE.
REQ-024 STOP with rxs=0: pulse framing_err; discard the byte; rx_data and rx_valid are unchanged.
REQ-025 STOP with rxs=1 and a parity mismatch: pulse parity_err; discard the byte.
REQ-026 STOP with rxs=1 and no mismatch: on the next clk, load rx_data and set rx_valid=1.
REQ-027 Overrun: if rx_valid=1 and rx_ack=0 on the cycle a good byte loads, the new byte overwrites rx_data and overrun is set.
REQ-028 rx_ack on the same cycle as a load: the load wins; rx_valid stays 1 and overrun is not set.
REQ-029 rx_ack without a load: clear rx_valid and overrun on the next clk.
REQ-030 enable deasserted outside IDLE: abort to IDLE on the next clk; the partial byte is discarded and no flag is raised.
REQ-031 Because IDLE requires a falling edge, a line held low (break) SHALL NOT retrigger reception until rxs returns to 1.
REQ-032 Latency from the mid-stop-bit tick to rx_valid SHALL be 1 clk; each error pulse is asserted for exactly 1 clk at that same point.
REQ-033 Counter widths SHALL be sized from OVERSAMPLE with no wrap inside a bit; the bit counter counts 0 to 7.

Reset
REQ-034 While rst=0, the state is IDLE and all counters and the shift register are 0; the synchronizer flops are 1.
REQ-035 While rst=0, rx_data=0x00 and rx_valid=framing_err=parity_err=overrun=busy=0.
REQ-036 Reset asserted mid-frame SHALL abort the frame immediately; after release, the next falling edge starts a fresh frame.

Verification
REQ-037 OVERSAMPLE=16, frame 0xA5 (8N1), then rx_ack -> rx_valid=1 and rx_data=0xA5 one clk after the mid-stop tick; rx_valid=0 after the ack.
REQ-038 Low pulse on rx lasting 4 ticks while idle -> returns to IDLE with busy=0; rx_valid, framing_err and parity_err all stay 0.
REQ-039 Frame 0x3C with stop bit forced to 0 -> 1-clk framing_err pulse, rx_valid stays 0, rx_data unchanged.
REQ-040 Frames 0x11 then 0x22 with no ack -> rx_data=0x22 and overrun=1; rx_ack -> rx_valid=0 and overrun=0.
REQ-041 PARITY_EN=1, PARITY_ODD=0, byte 0x07 with parity bit 0 -> parity_err pulse and no rx_valid; the same byte with parity bit 1 -> rx_data=0x07.
REQ-042 rst=0 during bit 4 of a frame -> all outputs return to reset values; a following frame 0x5A is received correctly.
